// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational-result ALU between two requesters.
// Round-robin grant in IDLE, operands registered onto the ALU, a fixed settle
// count in EXEC, then the captured result/flags are held in RESP until the
// winner takes them. One operation in flight at a time.
// Optional feature: define ALU_ARB_LOCK_EN to add req0_lock/req1_lock, which
// let a grantee reserve up to LOCK_MAX back-to-back grants.
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1,
    parameter int LOCK_MAX    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic             req0_lock,
    input  logic             req1_lock,
`endif
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_cout,
    output logic [2:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Settle counter is loaded with latency-1 so that latency 1 captures on
    // the first EXEC edge.
    localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

    state_t           state_q;
    logic             last_grant_q;
    logic             id_q;
    logic [2:0]       cnt_q;
    logic [2:0]       alu_s_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q;
    logic             rsp_ovf_q;
    logic             rsp_cout_q;

    logic             grant;
    logic             grant_vld;
    logic             hs;

`ifdef ALU_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1) + 1;

    logic           lock_act_q;
    logic           lock_id_q;
    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_cnt_d;
    logic           lock_owner_vld;
    logic           grant_lock;
`endif

    // Grant selection: reserved owner first (if locking), else round-robin.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
`ifdef ALU_ARB_LOCK_EN
        lock_owner_vld = lock_id_q ? req1_valid : req0_valid;
        if (lock_act_q && lock_owner_vld)
            grant = lock_id_q;
        grant_lock = grant ? req1_lock : req0_lock;
        // A lock continuing the current run counts up; anything else starts a new run.
        lock_cnt_d = (lock_act_q && (lock_id_q == grant)) ? lock_cnt_q + 1'b1 : LCW'(1);
`endif
    end

    assign hs         = rst_n && (state_q == IDLE) && grant_vld;
    assign req0_ready = hs && !grant;
    assign req1_ready = hs && grant;

    // Main FSM: accept, hold operands for the settle count, capture, respond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= 3'd0;
            alu_s_q      <= 3'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_cout_q   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_act_q   <= 1'b0;
            lock_id_q    <= 1'b0;
            lock_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ALU_ARB_LOCK_EN
                    // Owner not presenting an op ends the reservation.
                    if (lock_act_q && !lock_owner_vld)
                        lock_act_q <= 1'b0;
`endif
                    if (hs) begin
                        id_q    <= grant;
                        alu_s_q <= grant ? req1_op : req0_op;
                        alu_a_q <= grant ? req1_a  : req0_a;
                        alu_b_q <= grant ? req1_b  : req0_b;
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
`ifdef ALU_ARB_LOCK_EN
                        if (grant_lock) begin
                            lock_id_q  <= grant;
                            lock_cnt_q <= lock_cnt_d;
                            lock_act_q <= (lock_cnt_d < LCW'(LOCK_MAX));
                        end else begin
                            lock_act_q <= 1'b0;
                            lock_cnt_q <= '0;
                        end
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q == 3'd0) begin
                        rsp_data_q <= alu_out;
                        rsp_zero_q <= alu_zero;
                        rsp_ovf_q  <= alu_overflow;
                        rsp_cout_q <= alu_cout;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (id_q ? rsp1_ready : rsp0_ready) begin
                        last_grant_q <= id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state_q == RESP) && !id_q;
    assign rsp1_valid = (state_q == RESP) && id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_cout   = rsp_cout_q;
    assign alu_s      = alu_s_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, directed vector table on a
// latency-1 instance, hand sequences for arbitration, backpressure, reset in
// flight, and a latency-3 instance. Lock grants checked when ALU_ARB_LOCK_EN is set.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A (latency 1)
    logic        r0v, r0r, r1v, r1r, s0v, s0r, s1v, s1r;
    logic [2:0]  r0op, r1op, as_;
    logic [31:0] r0a, r0b, r1a, r1b, rd, aa, ab, ao;
    logic        rz, ro, rc, az, aov, ac;
`ifdef ALU_ARB_LOCK_EN
    logic        r0lk, r1lk;
`endif

    // instance B (latency 3, requester 0 only)
    logic        c_r0v, c_r0r, c_r1r, c_s0v, c_s1v;
    logic [2:0]  c_r0op, c_as;
    logic [31:0] c_r0a, c_r0b, c_rd, c_aa, c_ab, c_ao;
    logic        c_rz, c_ro, c_rc, c_az, c_aov, c_ac;

    int tests = 0;
    int fails = 0;

    function automatic logic [34:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        o, c;
        t = '0; r = '0; o = 1'b0; c = 1'b0;
        case (s)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
                        o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin t = {1'b0, a} + {1'b0, ~b} + 33'd1; r = t[31:0]; c = t[32];
                        o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = {31'd0, ($signed(a) < $signed(b))};
            3'd3: r = a ^ b;
            3'd4: r = a << b[4:0];
            3'd5: r = a >> b[4:0];
            3'd6: r = 32'($signed(a) >>> b[4:0]);
            default: r = a & b;
        endcase
        return {c, o, (r == 32'd0), r};
    endfunction

    always_comb {ac, aov, az, ao} = alu_f(as_, aa, ab);
    always_comb {c_ac, c_aov, c_az, c_ao} = alu_f(c_as, c_aa, c_ab);

    alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(1), .LOCK_MAX(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(r0lk), .req1_lock(r1lk),
`endif
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp1_valid(s1v), .rsp1_ready(s1r),
        .rsp_data(rd), .rsp_zero(rz), .rsp_ovf(ro), .rsp_cout(rc),
        .alu_s(as_), .alu_a(aa), .alu_b(ab),
        .alu_out(ao), .alu_zero(az), .alu_overflow(aov), .alu_cout(ac)
    );

    alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(3), .LOCK_MAX(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(c_r0v), .req0_ready(c_r0r), .req0_op(c_r0op), .req0_a(c_r0a), .req0_b(c_r0b),
        .req1_valid(1'b0), .req1_ready(c_r1r), .req1_op(3'd0), .req1_a(32'd0), .req1_b(32'd0),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(1'b0), .req1_lock(1'b0),
`endif
        .rsp0_valid(c_s0v), .rsp0_ready(1'b1), .rsp1_valid(c_s1v), .rsp1_ready(1'b1),
        .rsp_data(c_rd), .rsp_zero(c_rz), .rsp_ovf(c_ro), .rsp_cout(c_rc),
        .alu_s(c_as), .alu_a(c_aa), .alu_b(c_ab),
        .alu_out(c_ao), .alu_zero(c_az), .alu_overflow(c_aov), .alu_cout(c_ac)
    );

    typedef struct {
        logic        who;
        logic [2:0]  op;
        logic [31:0] a, b, d;
        logic [2:0]  f;   // {zero, ovf, cout}
    } vec_t;

    vec_t tv[10];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One op on instance A with response ready; checks exact latency-1 timing.
    task automatic run_op(input logic who, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input logic [2:0] ef);
        int n;
        s0r = 1'b1; s1r = 1'b1;
        if (who) begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; end
        else     begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; end
        #0;
        n = 0;
        while (!(who ? r1r : r0r) && n < 20) begin tick(); n++; end
        chk("accept_in_time", 32'(n < 20), 32'd1);
        tick();
        r0v = 1'b0; r1v = 1'b0;
        chk("exec_alu_s", 32'(as_), 32'(op));
        chk("exec_alu_a", aa, a);
        chk("exec_alu_b", ab, b);
        chk("exec_no_ready", {30'd0, r0r, r1r}, 32'd0);
        chk("exec_no_rsp", {30'd0, s0v, s1v}, 32'd0);
        tick();
        chk("resp_valid", {30'd0, s0v, s1v}, who ? 32'd1 : 32'd2);
        chk("resp_alu_a_held", aa, a);
        chk("resp_data", rd, ed);
        chk("resp_flags", {29'd0, rz, ro, rc}, 32'(ef));
        tick();
        chk("resp_done", {30'd0, s0v, s1v}, 32'd0);
    endtask

    // Both requesters valid after reset; records the first n grant ids.
    task automatic run_both(input int n, input logic lk0, output logic [3:0] g);
        int k, cyc;
        logic both;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        g = '0; k = 0; both = 1'b0;
        s0r = 1'b1; s1r = 1'b1;
        r0op = 3'd0; r0a = 32'd1; r0b = 32'd2;   // add -> 3
        r1op = 3'd3; r1a = 32'd6; r1b = 32'd3;   // xor -> 5
`ifdef ALU_ARB_LOCK_EN
        r0lk = lk0; r1lk = 1'b0;
`else
        if (lk0) both = 1'b0;
`endif
        r0v = 1'b1; r1v = 1'b1;
        #0;
        for (cyc = 0; cyc < 60 && k < n; cyc++) begin
            if (r0r && r1r) both = 1'b1;
            if (s0v) chk("rr_rsp0_data", rd, 32'd3);
            if (s1v) chk("rr_rsp1_data", rd, 32'd5);
            if (r0r || r1r) begin g[k] = r1r; k++; end
            tick();
        end
        r0v = 1'b0; r1v = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        r0lk = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            if (s0v) chk("rr_rsp0_data", rd, 32'd3);
            if (s1v) chk("rr_rsp1_data", rd, 32'd5);
            tick();
        end
        chk("rr_grant_count", 32'(k), 32'(n));
        chk("rr_never_both_ready", 32'(both), 32'd0);
    endtask

    initial begin
        logic [3:0] g;
        int n;
        tv[0] = '{1'b0, 3'd0, 32'd5,        32'd7,        32'd12,       3'b000};
        tv[1] = '{1'b1, 3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        3'b101};
        tv[2] = '{1'b0, 3'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 3'b010};
        tv[3] = '{1'b1, 3'd1, 32'd3,        32'd3,        32'd0,        3'b101};
        tv[4] = '{1'b0, 3'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 3'b000};
        tv[5] = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'd1,        32'd1,        3'b000};
        tv[6] = '{1'b0, 3'd3, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 3'b000};
        tv[7] = '{1'b1, 3'd4, 32'd1,        32'd31,       32'h80000000, 3'b000};
        tv[8] = '{1'b0, 3'd6, 32'h80000000, 32'd4,        32'hF8000000, 3'b000};
        tv[9] = '{1'b1, 3'd5, 32'h80000000, 32'd4,        32'h08000000, 3'b000};

        r0v = 1'b1; r1v = 1'b1; r0op = 3'd0; r1op = 3'd0;
        r0a = 32'd1; r0b = 32'd1; r1a = 32'd1; r1b = 32'd1;
        s0r = 1'b1; s1r = 1'b1;
        c_r0v = 1'b1; c_r0op = 3'd0; c_r0a = 32'd0; c_r0b = 32'd0;
`ifdef ALU_ARB_LOCK_EN
        r0lk = 1'b0; r1lk = 1'b0;
`endif
        // reset state with requests pending
        tick(); tick();
        chk("rst_ready", {29'd0, r0r, r1r, c_r0r}, 32'd0);
        chk("rst_rsp_valid", {30'd0, s0v, s1v}, 32'd0);
        chk("rst_alu", aa | ab | 32'(as_), 32'd0);
        chk("rst_rsp", rd | {29'd0, rz, ro, rc}, 32'd0);
        r0v = 1'b0; r1v = 1'b0; c_r0v = 1'b0;
        rst_n = 1'b1;
        tick();

        // directed vectors
        for (int i = 0; i < 10; i++)
            run_op(tv[i].who, tv[i].op, tv[i].a, tv[i].b, tv[i].d, tv[i].f);

        // round-robin under continuous contention
        run_both(4, 1'b0, g);
        chk("rr_grants", 32'(g), 32'b1010);

        // backpressure: req1 response held, req0 waits
        r1v = 1'b1; r1op = 3'd1; r1a = 32'd3; r1b = 32'd3; s1r = 1'b0;
        #0;
        chk("bp_req1_ready", 32'(r1r), 32'd1);
        tick();
        r1v = 1'b0;
        r0v = 1'b1; r0op = 3'd0; r0a = 32'd5; r0b = 32'd7;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_held", {30'd0, s0v, s1v}, 32'd1);
            chk("bp_data", rd, 32'd0);
            chk("bp_flags", {29'd0, rz, ro, rc}, 32'b101);
            chk("bp_req0_blocked", 32'(r0r), 32'd0);
            tick();
        end
        s1r = 1'b1;
        tick();
        chk("bp_req0_after_release", 32'(r0r), 32'd1);
        tick();
        r0v = 1'b0;
        tick();
        chk("bp_req0_rsp", {31'd0, s0v}, 32'd1);
        chk("bp_req0_data", rd, 32'd12);
        tick();

        // reset while in EXEC
        r0v = 1'b1; r0op = 3'd0; r0a = 32'd9; r0b = 32'd9;
        #0;
        chk("rx_accept", 32'(r0r), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rx_ready", {30'd0, r0r, r1r}, 32'd0);
        chk("rx_rsp_valid", {30'd0, s0v, s1v}, 32'd0);
        chk("rx_alu", aa | ab | 32'(as_), 32'd0);
        chk("rx_rsp", rd | {29'd0, rz, ro, rc}, 32'd0);
        tick();
        chk("rx_no_rsp_later", {30'd0, s0v, s1v}, 32'd0);
        r0v = 1'b0;
        rst_n = 1'b1;
        run_op(1'b0, 3'd0, 32'd20, 32'd22, 32'd42, 3'b000);

        // latency-3 instance
        c_r0v = 1'b1; c_r0op = 3'd3; c_r0a = 32'hF0F0F0F0; c_r0b = 32'hFFFFFFFF;
        #0;
        chk("l3_accept", 32'(c_r0r), 32'd1);
        tick();
        c_r0v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("l3_no_rsp_yet", 32'(c_s0v), 32'd0);
            chk("l3_alu_b_held", c_ab, 32'hFFFFFFFF);
            tick();
        end
        n = 0;
        chk("l3_rsp_valid", 32'(c_s0v), 32'd1);
        chk("l3_data", c_rd, 32'h0F0F0F0F);
        chk("l3_flags", {29'd0, c_rz, c_ro, c_rc}, 32'd0);
        tick();
        chk("l3_done", 32'(c_s0v | c_s1v | c_r1r), 32'd0);

        // lock behaviour (LOCK_MAX=2 on instance A)
        run_both(3, 1'b1, g);
`ifdef ALU_ARB_LOCK_EN
        chk("lock_grants", 32'(g[2:0]), 32'b100);
`else
        chk("lock_grants", 32'(g[2:0]), 32'b010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
